// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution frame streamer.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CONV,
    RELEASE,
    STREAM
  } stream_state_t;

  localparam int DEFAULT_HEIGHT = 5;
  localparam int DEFAULT_WIDTH  = 5;
  localparam int FRAME_PIXELS   = DEFAULT_HEIGHT * DEFAULT_WIDTH;
  localparam int ROW_WIDTH      = $clog2(DEFAULT_HEIGHT);
  localparam int COL_WIDTH      = $clog2(DEFAULT_WIDTH);

  // A one-row or one-column frame still needs a 1-bit counter.
  function automatic int counterWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_quantizer.sv
// Converts one signed fixed-point conv result into an unsigned saturated pixel:
// magnitude (or clamp-at-zero), drop the fraction, saturate to OUT_WIDTH bits.
module pixel_quantizer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int ABS_MODE   = 1
) (
  input  logic signed [DATA_WIDTH-1:0] pixel_i,
  output logic        [OUT_WIDTH-1:0]  pixel_o
);

  localparam logic [DATA_WIDTH:0] MAX_CODE = (DATA_WIDTH + 1)'((1 << OUT_WIDTH) - 1);

  logic signed [DATA_WIDTH:0] pixelExt;
  logic        [DATA_WIDTH:0] magnitude;
  logic        [DATA_WIDTH:0] integerPart;

  // One extra bit so negating the most-negative input cannot overflow.
  assign pixelExt = {pixel_i[DATA_WIDTH-1], pixel_i};

  always_comb begin
    magnitude = $unsigned(pixelExt);
    if (pixel_i[DATA_WIDTH-1]) begin
      if (ABS_MODE != 0) begin
        magnitude = $unsigned(-pixelExt);
      end else begin
        magnitude = '0;
      end
    end
    integerPart = magnitude >> FRAC_BITS;
    pixel_o     = (integerPart > MAX_CODE) ? OUT_WIDTH'(MAX_CODE) : integerPart[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/conv_frame_streamer.sv
// Frame initiator and drain for the convolution unit: triggers a conv pass, captures
// the result array and streams it out as quantised pixels in raster order.
module conv_frame_streamer
  import conv_pkg::*;
#(
  parameter int IMAGE_HEIGHT = DEFAULT_HEIGHT,
  parameter int IMAGE_WIDTH  = DEFAULT_WIDTH,
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int OUT_WIDTH    = 8,
  parameter int ABS_MODE     = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  output logic                         conv_enable,
  input  logic                         conv_done,
  input  logic signed [DATA_WIDTH-1:0] conv_image [IMAGE_HEIGHT][IMAGE_WIDTH],
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [OUT_WIDTH-1:0]         m_data,
  output logic                         m_first,
  output logic                         m_last,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int ROW_W = counterWidth(IMAGE_HEIGHT);
  localparam int COL_W = counterWidth(IMAGE_WIDTH);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 1);

  stream_state_t state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic convEnable_q, convEnable_d;
  logic frameDone_q, frameDone_d;
  logic capture;
  logic signed [DATA_WIDTH-1:0] frameBuf_q [IMAGE_HEIGHT][IMAGE_WIDTH];
  logic [OUT_WIDTH-1:0] quantPixel;
  logic inStream, atLastCol, atLastPixel;

  assign inStream    = (state_q == STREAM);
  assign atLastCol   = (col_q == LAST_COL);
  assign atLastPixel = atLastCol && (row_q == LAST_ROW);

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    convEnable_d = convEnable_q;
    frameDone_d  = 1'b0;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          convEnable_d = 1'b1;
          state_d      = WAIT_CONV;
        end
      end
      WAIT_CONV: begin
        if (conv_done) begin
          capture      = 1'b1;
          convEnable_d = 1'b0;
          row_d        = '0;
          col_d        = '0;
          state_d      = RELEASE;
        end
      end
      // Hold off until done drops so a stale done cannot start another capture.
      RELEASE: begin
        if (!conv_done) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (m_ready) begin
          if (atLastPixel) begin
            row_d       = '0;
            col_d       = '0;
            frameDone_d = 1'b1;
            state_d     = IDLE;
          end else if (atLastCol) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      convEnable_q <= 1'b0;
      frameDone_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      convEnable_q <= convEnable_d;
      frameDone_q  <= frameDone_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < IMAGE_HEIGHT; r++) begin
        for (int c = 0; c < IMAGE_WIDTH; c++) begin
          frameBuf_q[r][c] <= '0;
        end
      end
    end else if (capture) begin
      frameBuf_q <= conv_image;
    end
  end

  pixel_quantizer #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .OUT_WIDTH (OUT_WIDTH),
    .ABS_MODE  (ABS_MODE)
  ) quantizer (
    .pixel_i(frameBuf_q[row_q][col_q]),
    .pixel_o(quantPixel)
  );

  // Stream outputs come only from registered state, never from m_ready.
  assign m_valid     = inStream;
  assign m_data      = inStream ? quantPixel : '0;
  assign m_first     = inStream && (row_q == '0) && (col_q == '0);
  assign m_last      = inStream && atLastPixel;
  assign conv_enable = convEnable_q;
  assign frame_done  = frameDone_q;
  assign busy        = (state_q != IDLE);

endmodule
